// File: rtl/uart_byte_rx.sv
// UART byte receiver: 16x-oversampled serial line, majority-vote bit decisions, 8N1 frames.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and enables parity checking.
module uart_byte_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] baud_set,
    input  logic       Rs232_Rx,
    output logic [7:0] data_byte,
    output logic       Rx_Done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    // Clock cycles per oversample tick for a given baud selection.
    function automatic logic [15:0] baud_div(input logic [2:0] sel);
        int baud;
        case (sel)
            3'd1:    baud = 32'd19200;
            3'd2:    baud = 32'd38400;
            3'd3:    baud = 32'd57600;
            3'd4:    baud = 32'd115200;
            default: baud = 32'd9600;
        endcase
        return 16'(CLK_FREQ / (baud * OVERSAMPLE));
    endfunction

`ifdef UART_RX_PARITY_EN
    // Returns 1 when data plus parity bit fail the even-parity rule.
    function automatic logic even_parity_bad(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction
`endif

    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_prev_r;
    logic [1:0]  flush_r;
    logic        armed_r;
    rx_state_t   fsm_r;
    logic [2:0]  baud_r;
    logic [15:0] div_cnt_r;
    logic [3:0]  t_idx_r;
    logic        s6_r;
    logic        s7_r;
    logic [7:0]  shift_r;
    logic [2:0]  bit_cnt_r;
`ifdef UART_RX_PARITY_EN
    logic        par_bit_r;
`endif

    logic [15:0] div_s;
    logic        fall_s;
    logic        start_s;
    logic        tick_s;
    logic [3:0]  nxt_t_s;
    logic        decide_s;
    logic        bit_end_s;
    logic        maj_s;

    assign div_s     = baud_div(baud_r);
    assign fall_s    = rx_prev_r & ~rx_sync_r;
    assign start_s   = (fsm_r == IDLE) & armed_r & fall_s;
    assign tick_s    = (div_cnt_r >= (div_s - 16'd1));
    assign nxt_t_s   = t_idx_r + 4'd1;
    assign decide_s  = tick_s & (nxt_t_s == 4'd8);
    assign bit_end_s = tick_s & (nxt_t_s == 4'd0);
    // t=8 sample is the live synchronized line; t=6 and t=7 were latched earlier.
    assign maj_s     = (s6_r & s7_r) | (s6_r & rx_sync_r) | (s7_r & rx_sync_r);

    // Two-flop synchronizer plus arming once the flushed line is seen high.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
            flush_r   <= 2'b00;
            armed_r   <= 1'b0;
        end else begin
            rx_meta_r <= Rs232_Rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            flush_r   <= {flush_r[0], 1'b1};
            armed_r   <= armed_r | (flush_r[1] & rx_sync_r);
        end
    end

    // Oversample tick divider, re-phased to each detected start edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_cnt_r <= 16'd0;
        end else if (start_s || tick_s) begin
            div_cnt_r <= 16'd0;
        end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
        end
    end

    // Frame FSM: bit timing, majority sampling, shift register and result pulses.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            fsm_r      <= IDLE;
            baud_r     <= 3'd0;
            t_idx_r    <= 4'd0;
            s6_r       <= 1'b1;
            s7_r       <= 1'b1;
            shift_r    <= 8'd0;
            bit_cnt_r  <= 3'd0;
`ifdef UART_RX_PARITY_EN
            par_bit_r  <= 1'b0;
`endif
            data_byte  <= 8'd0;
            Rx_Done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            state      <= 1'b0;
        end else begin
            Rx_Done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;

            if (start_s) begin
                t_idx_r <= 4'd0;
            end else if (tick_s) begin
                t_idx_r <= nxt_t_s;
            end
            if (tick_s && (nxt_t_s == 4'd6)) begin
                s6_r <= rx_sync_r;
            end
            if (tick_s && (nxt_t_s == 4'd7)) begin
                s7_r <= rx_sync_r;
            end

            case (fsm_r)
                IDLE: begin
                    if (start_s) begin
                        fsm_r  <= START;
                        state  <= 1'b1;
                        baud_r <= baud_set;
                    end
                end
                START: begin
                    if (decide_s && maj_s) begin
                        fsm_r <= IDLE;
                        state <= 1'b0;
                    end else if (bit_end_s) begin
                        fsm_r     <= DATA;
                        bit_cnt_r <= 3'd0;
                    end
                end
                DATA: begin
                    if (decide_s) begin
                        shift_r <= {maj_s, shift_r[7:1]};
                    end
                    if (bit_end_s) begin
                        if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            fsm_r <= PARITY;
`else
                            fsm_r <= STOP;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (decide_s) begin
                        par_bit_r <= maj_s;
                    end
                    if (bit_end_s) begin
                        fsm_r <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leaving at t=8 keeps back-to-back start edges visible in IDLE.
                    if (decide_s) begin
                        if (maj_s) begin
                            data_byte <= shift_r;
                            Rx_Done   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= even_parity_bad(shift_r, par_bit_r);
`endif
                            fsm_r     <= IDLE;
                            state     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            fsm_r     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_sync_r) begin
                        fsm_r <= IDLE;
                        state <= 1'b0;
                    end
                end
                default: begin
                    fsm_r <= IDLE;
                    state <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed self-checking bench for uart_byte_rx; follows UART_RX_PARITY_EN when defined.
module tb_uart_byte_rx;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [2:0] baud_set = 3'd4;
    logic       Rs232_Rx = 1'b1;
    logic [7:0] data_byte;
    logic       Rx_Done;
    logic       frame_err;
    logic       parity_err;
    logic       state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int edge_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int wide_cnt = 0;
    int excl_cnt = 0;
    logic prev_done = 1'b0;
    logic [7:0] done_q[$];
    logic perr_q[$];

`ifdef UART_RX_PARITY_EN
    localparam int FRAME_TICKS = 168;
`else
    localparam int FRAME_TICKS = 152;
`endif

    uart_byte_rx dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .baud_set  (baud_set),
        .Rs232_Rx  (Rs232_Rx),
        .data_byte (data_byte),
        .Rx_Done   (Rx_Done),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .state     (state)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    // Pulse monitor sampled on the falling edge.
    always @(negedge Clk) begin
        if (Rx_Done) begin
            done_cnt++;
            done_q.push_back(data_byte);
            perr_q.push_back(parity_err);
            done_cyc = cyc;
        end
        if (Rx_Done && prev_done) wide_cnt++;
        prev_done = Rx_Done;
        if (frame_err) ferr_cnt++;
        if (parity_err) perr_cnt++;
        if ((Rx_Done && frame_err) || (frame_err && parity_err)) excl_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int bc);
        Rs232_Rx = 1'b0;
        edge_cyc = cyc;
        wait_cyc(bc);
        for (int i = 0; i < 8; i++) begin
            Rs232_Rx = b[i];
            wait_cyc(bc);
        end
`ifdef UART_RX_PARITY_EN
        Rs232_Rx = par;
        wait_cyc(bc);
`endif
        Rs232_Rx = stp;
        wait_cyc(bc);
    endtask

    task automatic check_latency(input string tag, input int div);
        int lat;
        lat = done_cyc - edge_cyc;
        check(tag, 32'((lat >= FRAME_TICKS * div - div) && (lat <= FRAME_TICKS * div + div + 3)), 32'd1);
    endtask

    initial begin
        int d0;
        int f0;

        // Reset state
        wait_cyc(5);
        check("rst_data_byte", 32'(data_byte), 32'h00);
        check("rst_rx_done", 32'(Rx_Done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        Rst = 1'b0;
        wait_cyc(20);

        // Single byte 0x9E at 115200
        send_frame(8'h9E, 1'b1, 1'b1, 434);
        wait_cyc(50);
        check("b1_done_cnt", 32'(done_cnt), 32'd1);
        check("b1_data", 32'(done_q[0]), 32'h9E);
        check("b1_pulse_width", 32'(wide_cnt), 32'd0);
        check_latency("b1_latency", 27);
        check("b1_frame_err", 32'(ferr_cnt), 32'd0);
        check("b1_state", 32'(state), 32'd0);

        // Back-to-back 0x55, 0xAA with a single stop bit
        send_frame(8'h55, 1'b0, 1'b1, 434);
        send_frame(8'hAA, 1'b0, 1'b1, 434);
        wait_cyc(50);
        check("b2b_done_cnt", 32'(done_cnt), 32'd3);
        check("b2b_first", 32'(done_q[1]), 32'h55);
        check("b2b_second", 32'(done_q[2]), 32'hAA);
        check("b2b_frame_err", 32'(ferr_cnt), 32'd0);

        // Short low glitch of 81 cycles is rejected
        Rs232_Rx = 1'b0;
        wait_cyc(40);
        check("glitch_state_busy", 32'(state), 32'd1);
        wait_cyc(41);
        Rs232_Rx = 1'b1;
        wait_cyc(160);
        check("glitch_state_idle", 32'(state), 32'd0);
        check("glitch_no_done", 32'(done_cnt), 32'd3);
        wait_cyc(100);
        send_frame(8'h3C, 1'b0, 1'b1, 434);
        wait_cyc(50);
        check("glitch_next_cnt", 32'(done_cnt), 32'd4);
        check("glitch_next_data", 32'(done_q[3]), 32'h3C);

        // Bad stop bit, line held low, then released
        send_frame(8'hA5, 1'b0, 1'b0, 434);
        wait_cyc(868);
        check("ferr_state_held", 32'(state), 32'd1);
        check("ferr_pulse_cnt", 32'(ferr_cnt), 32'd1);
        Rs232_Rx = 1'b1;
        wait_cyc(20);
        check("ferr_state_idle", 32'(state), 32'd0);
        check("ferr_no_done", 32'(done_cnt), 32'd4);
        check("ferr_data_kept", 32'(data_byte), 32'h3C);

        // Reset during data bit 4 of 0xFF, then 0x12
        wait_cyc(100);
        d0 = done_cnt;
        f0 = ferr_cnt;
        Rs232_Rx = 1'b0;
        wait_cyc(434);
        Rs232_Rx = 1'b1;
        wait_cyc(4 * 434 + 200);
        Rst = 1'b1;
        wait_cyc(1);
        check("mrst_data_byte", 32'(data_byte), 32'h00);
        check("mrst_state", 32'(state), 32'd0);
        Rst = 1'b0;
        wait_cyc(6 * 434);
        check("mrst_no_pulse", 32'(done_cnt - d0 + ferr_cnt - f0), 32'd0);
        send_frame(8'h12, 1'b0, 1'b1, 434);
        wait_cyc(50);
        check("mrst_next_cnt", 32'(done_cnt - d0), 32'd1);
        check("mrst_next_data", 32'(data_byte), 32'h12);

        // 57600 baud; baud_set change mid-frame must be ignored
        baud_set = 3'd3;
        fork
            send_frame(8'h81, 1'b0, 1'b1, 868);
            begin
                wait_cyc(1000);
                baud_set = 3'd0;
            end
        join
        wait_cyc(50);
        check("b57k_done_cnt", 32'(done_cnt - d0), 32'd2);
        check("b57k_data", 32'(data_byte), 32'h81);
        check_latency("b57k_latency", 54);

`ifdef UART_RX_PARITY_EN
        // Parity check: 0x07 with correct then wrong parity bit
        baud_set = 3'd4;
        wait_cyc(100);
        send_frame(8'h07, 1'b1, 1'b1, 434);
        wait_cyc(50);
        check("par_ok_done", 32'(done_cnt - d0), 32'd3);
        check("par_ok_data", 32'(data_byte), 32'h07);
        check("par_ok_flag", 32'(perr_q[perr_q.size() - 1]), 32'd0);
        send_frame(8'h07, 1'b0, 1'b1, 434);
        wait_cyc(50);
        check("par_bad_done", 32'(done_cnt - d0), 32'd4);
        check("par_bad_data", 32'(data_byte), 32'h07);
        check("par_bad_flag", 32'(perr_q[perr_q.size() - 1]), 32'd1);
        check("par_err_cnt", 32'(perr_cnt), 32'd1);
`else
        check("no_parity_err", 32'(perr_cnt), 32'd0);
`endif

        check("pulse_exclusive", 32'(excl_cnt), 32'd0);
        check("all_pulses_single", 32'(wide_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
